// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle between a FIFO producer/consumer and sync_fifo_flex.
// The master side drives requests; the slave side (the FIFO) drives data and status.
interface sync_fifo_flex_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, optional
// first-word-fall-through read port, synchronous flush and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_flex_if.slave  fifo_if
);
  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full, empty;
  logic              wa, ra;

  // Status comes straight from the registered count, never from pointer equality.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign wa = fifo_if.wr_en && !full  && !fifo_if.flush;
  assign ra = fifo_if.rd_en && !empty && !fifo_if.flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (fifo_if.wr_en && full  && !fifo_if.flush);
    udf_d   = udf_q | (fifo_if.rd_en && empty && !fifo_if.flush);
    if (fifo_if.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wa) wptr_d = wptr_q + 1'b1;
      if (ra) rptr_d = rptr_q + 1'b1;
      case ({wa, ra})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wa && !reset) mem_q[wptr_q] <= fifo_if.wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_if.rd_data  = mem_q[rptr_q];
      assign fifo_if.rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= ra;
          if (ra) rd_data_q <= mem_q[rptr_q];
        end
      end

      assign fifo_if.rd_data  = rd_data_q;
      assign fifo_if.rd_valid = rd_valid_q;
    end
  endgenerate

  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (count_q >= AFULL_C);
  assign fifo_if.almost_empty = (count_q <= AEMPTY_C);
  assign fifo_if.count        = count_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: a standard-mode instance driven by a
// scoreboarded step task and a vector table, plus an FWFT instance.
module tb_sync_fifo_flex;
  logic clk;
  logic reset;

  sync_fifo_flex_if #(.DATA_W(8), .ADDR_W(4)) s_if ();
  sync_fifo_flex_if #(.DATA_W(8), .ADDR_W(4)) f_if ();

  sync_fifo_flex #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk     (clk),
    .reset   (reset),
    .fifo_if (s_if.slave)
  );

  sync_fifo_flex #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk     (clk),
    .reset   (reset),
    .fifo_if (f_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model of the standard-mode instance
  logic [7:0] sb[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       fl;
    int         rep;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.flush = 1'b0; s_if.wr_data = 8'h00;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.flush = 1'b0; f_if.wr_data = 8'h00;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One clock on the standard instance; model predicts, DUT is checked after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic fl);
    logic       wa, ra;
    logic [7:0] exp_rd;
    exp_rd = 8'h00;
    s_if.wr_en = w; s_if.wr_data = d; s_if.rd_en = r; s_if.flush = fl;
    wa = w && (m_cnt != 16) && !fl;
    ra = r && (m_cnt != 0) && !fl;
    if (!fl && w && m_cnt == 16) m_ovf = 1'b1;
    if (!fl && r && m_cnt == 0)  m_udf = 1'b1;
    if (ra) exp_rd = sb.pop_front();
    if (wa) sb.push_back(d);
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + int'(wa) - int'(ra);
    end
    @(posedge clk); @(negedge clk);
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.flush = 1'b0;
    $display("txn w=%0d d=%02h r=%0d fl=%0d -> count=%0d rd_valid=%0d rd_data=%02h",
             w, d, r, fl, s_if.count, s_if.rd_valid, s_if.rd_data);
    check("count",        int'(s_if.count),        m_cnt);
    check("rd_valid",     int'(s_if.rd_valid),     int'(ra));
    if (ra) check("rd_data", int'(s_if.rd_data), int'(exp_rd));
    check("full",         int'(s_if.full),         int'(m_cnt == 16));
    check("empty",        int'(s_if.empty),        int'(m_cnt == 0));
    check("almost_full",  int'(s_if.almost_full),  int'(m_cnt >= 12));
    check("almost_empty", int'(s_if.almost_empty), int'(m_cnt <= 2));
    check("overflow",     int'(s_if.overflow),     int'(m_ovf));
    check("underflow",    int'(s_if.underflow),    int'(m_udf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           w     d      r     fl   rep cnt full  empty af    ae    ovf   udf
    tbl[0] = '{1'b1, 8'h40, 1'b1, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h41, 1'b0, 1'b0, 1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h42, 1'b0, 1'b0, 1,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h43, 1'b0, 1'b0, 8, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h4B, 1'b0, 1'b0, 1, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h4C, 1'b0, 1'b0, 4, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h99, 1'b1, 1'b0, 1, 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 13, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    do_reset();

    // Reset state, both instances
    check("rst_count",    int'(s_if.count), 0);
    check("rst_empty",    int'(s_if.empty), 1);
    check("rst_full",     int'(s_if.full), 0);
    check("rst_aempty",   int'(s_if.almost_empty), 1);
    check("rst_afull",    int'(s_if.almost_full), 0);
    check("rst_ovf",      int'(s_if.overflow), 0);
    check("rst_udf",      int'(s_if.underflow), 0);
    check("rst_rd_valid", int'(s_if.rd_valid), 0);
    check("rst_rd_data",  int'(s_if.rd_data), 0);
    check("rst_fwft_valid", int'(f_if.rd_valid), 0);
    check("rst_fwft_empty", int'(f_if.empty), 1);

    // FWFT: first word falls through without rd_en
    f_if.wr_en = 1'b1; f_if.wr_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    f_if.wr_en = 1'b0;
    $display("txn fwft write A5 -> rd_valid=%0d rd_data=%02h", f_if.rd_valid, f_if.rd_data);
    check("fwft_valid_after_wr", int'(f_if.rd_valid), 1);
    check("fwft_head_a5",        int'(f_if.rd_data), 8'hA5);
    @(posedge clk); @(negedge clk);
    check("fwft_head_held", int'(f_if.rd_data), 8'hA5);
    f_if.rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    f_if.rd_en = 1'b0;
    $display("txn fwft pop -> empty=%0d rd_valid=%0d", f_if.empty, f_if.rd_valid);
    check("fwft_empty_after_pop", int'(f_if.empty), 1);
    check("fwft_valid_after_pop", int'(f_if.rd_valid), 0);
    for (int i = 0; i < 2; i++) begin
      f_if.wr_en = 1'b1; f_if.wr_data = (i == 0) ? 8'h11 : 8'h22;
      @(posedge clk); @(negedge clk);
    end
    f_if.wr_en = 1'b0;
    check("fwft_head_11", int'(f_if.rd_data), 8'h11);
    f_if.rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    f_if.rd_en = 1'b0;
    $display("txn fwft pop -> rd_data=%02h count=%0d", f_if.rd_data, f_if.count);
    check("fwft_head_22", int'(f_if.rd_data), 8'h22);
    check("fwft_count_1", int'(f_if.count), 1);

    // Fill / overflow / drain
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full",  int'(s_if.full), 1);
    check("fill_count", int'(s_if.count), 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set",        int'(s_if.overflow), 1);
    check("ovf_count_held", int'(s_if.count), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", int'(s_if.empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Table-driven boundaries: read+write on empty and on full, threshold edges
    do_reset();
    foreach (tbl[t]) begin
      for (int k = 0; k < tbl[t].rep; k++)
        step(tbl[t].w, tbl[t].d + 8'(k), tbl[t].r, tbl[t].fl);
      check($sformatf("tbl%0d_count", t), int'(s_if.count), tbl[t].cnt);
      check($sformatf("tbl%0d_full", t),  int'(s_if.full),  int'(tbl[t].full));
      check($sformatf("tbl%0d_empty", t), int'(s_if.empty), int'(tbl[t].empty));
      check($sformatf("tbl%0d_af", t),    int'(s_if.almost_full),  int'(tbl[t].af));
      check($sformatf("tbl%0d_ae", t),    int'(s_if.almost_empty), int'(tbl[t].ae));
      check($sformatf("tbl%0d_ovf", t),   int'(s_if.overflow),  int'(tbl[t].ovf));
      check($sformatf("tbl%0d_udf", t),   int'(s_if.underflow), int'(tbl[t].udf));
    end

    // Steady read+write at count 5 across pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h65 + 8'(i), 1'b1, 1'b0);
    check("rw_count_5", int'(s_if.count), 5);
    check("rw_no_ovf",  int'(s_if.overflow), 0);
    check("rw_no_udf",  int'(s_if.underflow), 0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 9 with requests pending; underflow must survive
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    check("flush_count",    int'(s_if.count), 0);
    check("flush_empty",    int'(s_if.empty), 1);
    check("flush_rd_valid", int'(s_if.rd_valid), 0);
    check("flush_udf_kept", int'(s_if.underflow), 1);
    check("flush_ovf_kept", int'(s_if.overflow), 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_flush_3c", int'(s_if.rd_data), 8'h3C);

    // Reset mid-stream with count 7 and both sticky flags set
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_count", int'(s_if.count), 7);
    reset = 1'b1; s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.wr_data = 8'h77;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    $display("txn mid-stream reset -> count=%0d rd_data=%02h", s_if.count, s_if.rd_data);
    check("mrst_count",    int'(s_if.count), 0);
    check("mrst_empty",    int'(s_if.empty), 1);
    check("mrst_full",     int'(s_if.full), 0);
    check("mrst_aempty",   int'(s_if.almost_empty), 1);
    check("mrst_afull",    int'(s_if.almost_full), 0);
    check("mrst_ovf",      int'(s_if.overflow), 0);
    check("mrst_udf",      int'(s_if.underflow), 0);
    check("mrst_rd_valid", int'(s_if.rd_valid), 0);
    check("mrst_rd_data",  int'(s_if.rd_data), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
